// File: rtl/io_map_pkg.sv
// rtl/io_map_pkg.sv - I/O address map, decode helper and 7-segment font for io_bridge
package io_map_pkg;

  localparam logic [19:0] IO_BASE_DEFAULT = 20'hFFFFF;

  localparam logic [11:0] OFF_SEG   = 12'h000;
  localparam logic [11:0] OFF_TIMER = 12'h020;
  localparam logic [11:0] OFF_LED   = 12'h060;
  localparam logic [11:0] OFF_SW    = 12'h070;

  // Active-low {dp,g,f,e,d,c,b,a}; entry 0 is the least significant byte.
  localparam logic [15:0][7:0] SEG_FONT = {
    8'h8E, 8'h86, 8'hA1, 8'hC6, 8'h83, 8'h88, 8'h90, 8'h80,
    8'hF8, 8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hC0
  };

  typedef enum logic [2:0] {
    SEL_NONE, SEL_SEG, SEL_TIMER, SEL_LED, SEL_SW
  } io_sel_e;

  typedef enum logic [2:0] {
    DIG0, DIG1, DIG2, DIG3, DIG4, DIG5, DIG6, DIG7
  } digit_e;

  function automatic io_sel_e decode_sel(input logic [9:0] word_off);
    logic [11:0] off;
    off = {word_off, 2'b00};
    case (off)
      OFF_SEG:   return SEL_SEG;
      OFF_TIMER: return SEL_TIMER;
      OFF_LED:   return SEL_LED;
      OFF_SW:    return SEL_SW;
      default:   return SEL_NONE;
    endcase
  endfunction

endpackage

// File: rtl/io_bridge_if.sv
// rtl/io_bridge_if.sv - core data-port bus between CPU core/data RAM and io_bridge
interface io_bridge_if;

  logic [31:0] addr;
  logic [31:0] wdata;
  logic        we;
  logic [31:0] dram_rdata;
  logic [31:0] rdata;
  logic        dram_we;

  modport master (
    output addr, wdata, we, dram_rdata,
    input  rdata, dram_we
  );

  modport slave (
    input  addr, wdata, we, dram_rdata,
    output rdata, dram_we
  );

endinterface

// File: rtl/seg_scan.sv
// rtl/seg_scan.sv - multiplexed 8-digit 7-segment scanner with hex font lookup
module seg_scan
  import io_map_pkg::*;
#(
  parameter int SCAN_DIV = 50000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] data,
  output logic [7:0]  seg_an,
  output logic [7:0]  seg_cx
);

  localparam int CW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CW-1:0] DIV_LAST = CW'(SCAN_DIV - 1);

  logic [CW-1:0] div_q, div_d;
  digit_e        dig_q, dig_d;
  logic [3:0]    nibble;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q <= '0;
      dig_q <= DIG0;
    end else begin
      div_q <= div_d;
      dig_q <= dig_d;
    end
  end

  always_comb begin
    div_d  = div_q + 1'b1;
    dig_d  = dig_q;
    if (div_q == DIV_LAST) begin
      div_d = '0;
      dig_d = digit_e'(dig_q + 3'd1);
    end
    // Nibble follows data live so a SEG write shows on the lit digit next cycle.
    nibble = data[{dig_q, 2'b00} +: 4];
    seg_an = ~(8'h01 << dig_q);
    seg_cx = SEG_FONT[nibble] | 8'h80;
  end

endmodule

// File: rtl/io_bridge.sv
// rtl/io_bridge.sv - routes core loads/stores between data RAM and board I/O registers
module io_bridge
  import io_map_pkg::*;
#(
  parameter logic [19:0] IO_BASE  = IO_BASE_DEFAULT,
  parameter int          SCAN_DIV = 50000
) (
  input  logic        clk,
  input  logic        rst_n,
  io_bridge_if.slave  bus,
  input  logic [23:0] sw_in,
  output logic [23:0] led_out,
  output logic [7:0]  seg_an,
  output logic [7:0]  seg_cx
);

  logic        io_hit;
  io_sel_e     sel;
  logic        io_wr;
  logic [31:0] io_rdata;
  logic        unused_addr_lsb;

  logic [31:0] seg_q, seg_d;
  logic [31:0] timer_q, timer_d;
  logic [23:0] led_q, led_d;
  logic [23:0] sw_meta_q, sw_sync_q;

  assign io_hit          = (bus.addr[31:12] == IO_BASE);
  assign sel             = decode_sel(bus.addr[11:2]);
  assign io_wr           = bus.we & io_hit;
  assign unused_addr_lsb = ^bus.addr[1:0];

  assign bus.dram_we = bus.we & ~io_hit;
  assign bus.rdata   = io_hit ? io_rdata : bus.dram_rdata;
  assign led_out     = led_q;

  always_comb begin
    io_rdata = '0;
    case (sel)
      SEL_SEG:   io_rdata = seg_q;
      SEL_TIMER: io_rdata = timer_q;
      SEL_LED:   io_rdata = {8'h00, led_q};
      SEL_SW:    io_rdata = {8'h00, sw_sync_q};
      default:   io_rdata = '0;
    endcase
  end

  always_comb begin
    seg_d   = seg_q;
    led_d   = led_q;
    timer_d = timer_q + 32'd1;
    if (io_wr) begin
      case (sel)
        SEL_SEG:   seg_d   = bus.wdata;
        SEL_TIMER: timer_d = bus.wdata;
        SEL_LED:   led_d   = bus.wdata[23:0];
        default:   ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_q     <= '0;
      timer_q   <= '0;
      led_q     <= '0;
      sw_meta_q <= '0;
      sw_sync_q <= '0;
    end else begin
      seg_q     <= seg_d;
      timer_q   <= timer_d;
      led_q     <= led_d;
      sw_meta_q <= sw_in;
      sw_sync_q <= sw_meta_q;
    end
  end

  seg_scan #(
    .SCAN_DIV (SCAN_DIV)
  ) u_seg_scan (
    .clk    (clk),
    .rst_n  (rst_n),
    .data   (seg_q),
    .seg_an (seg_an),
    .seg_cx (seg_cx)
  );

endmodule

// File: tb/tb_io_bridge.sv
// tb/tb_io_bridge.sv - randomized self-checking bench for io_bridge against a behavioural model
module tb_io_bridge;

  localparam int DIV = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [23:0] sw_in;
  logic [23:0] led_out;
  logic [7:0]  seg_an;
  logic [7:0]  seg_cx;

  io_bridge_if bus();

  io_bridge #(.SCAN_DIV(DIV)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .bus     (bus),
    .sw_in   (sw_in),
    .led_out (led_out),
    .seg_an  (seg_an),
    .seg_cx  (seg_cx)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  logic [7:0] font_tbl [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

  logic [31:0] m_seg, m_timer;
  logic [23:0] m_led, m_sw1, m_sw2;
  int unsigned m_cyc;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_seg = 0; m_timer = 0; m_led = 0; m_sw1 = 0; m_sw2 = 0; m_cyc = 0;
  endtask

  function automatic logic is_io(input logic [31:0] a);
    return a[31:12] == 20'hFFFFF;
  endfunction

  function automatic logic [31:0] exp_rdata(input logic [31:0] a, input logic [31:0] dr);
    logic [11:0] off;
    if (!is_io(a)) return dr;
    off = {a[11:2], 2'b00};
    if (off == 12'h000) return m_seg;
    if (off == 12'h020) return m_timer;
    if (off == 12'h060) return {8'h0, m_led};
    if (off == 12'h070) return {8'h0, m_sw2};
    return 32'h0;
  endfunction

  function automatic logic [7:0] exp_an();
    int d;
    d = (m_cyc / DIV) % 8;
    return ~(8'd1 << d);
  endfunction

  function automatic logic [7:0] exp_cx();
    int d;
    d = (m_cyc / DIV) % 8;
    return font_tbl[m_seg[d*4 +: 4]];
  endfunction

  task automatic drive_cycle(input logic [31:0] a, input logic [31:0] wd, input logic w,
                             input logic [31:0] dr, input logic [23:0] sw);
    logic [11:0] off;
    bus.addr = a; bus.wdata = wd; bus.we = w; bus.dram_rdata = dr; sw_in = sw;
    #1;
    check("rdata",   bus.rdata, exp_rdata(a, dr));
    check("dram_we", {31'h0, bus.dram_we}, {31'h0, w & ~is_io(a)});
    check("led_out", {8'h0, led_out}, {8'h0, m_led});
    check("seg_an",  {24'h0, seg_an}, {24'h0, exp_an()});
    check("seg_cx",  {24'h0, seg_cx}, {24'h0, exp_cx()});
    off = {a[11:2], 2'b00};
    m_sw2 = m_sw1;
    m_sw1 = sw;
    if (w && is_io(a) && off == 12'h020) m_timer = wd;
    else                                  m_timer = m_timer + 1;
    if (w && is_io(a) && off == 12'h000) m_seg = wd;
    if (w && is_io(a) && off == 12'h060) m_led = wd[23:0];
    m_cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic peek(input logic [31:0] a, input logic [31:0] dr);
    bus.we = 1'b0; bus.addr = a; bus.dram_rdata = dr;
    #1;
  endtask

  task automatic apply_reset();
    bus.we = 1'b0;
    bus.addr = 32'hFFFF_F020;
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_led",   {8'h0, led_out}, 32'h0);
    check("rst_an",    {24'h0, seg_an}, 32'hFE);
    check("rst_cx",    {24'h0, seg_cx}, 32'hC0);
    check("rst_timer", bus.rdata, 32'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic rand_cycle();
    logic [31:0] a;
    logic [11:0] offs [6];
    int r;
    offs = '{12'h000, 12'h020, 12'h060, 12'h070, 12'h040, 12'h000};
    offs[5] = 12'($urandom);
    r = $urandom_range(0, 7);
    if (r < 3) a = $urandom & 32'h7FFF_FFFF;
    else       a = {20'hFFFFF, offs[$urandom_range(0, 5)] & 12'hFFC, 2'($urandom) | 12'h000};
    drive_cycle(a, $urandom, 1'($urandom), $urandom,
                ($urandom_range(0, 3) == 0) ? 24'($urandom) : sw_in);
  endtask

  initial begin
    rst_n = 1'b0;
    bus.addr = 0; bus.wdata = 0; bus.we = 0; bus.dram_rdata = 0;
    sw_in = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Routing
    drive_cycle(32'h0000_0100, 32'hDEAD_BEEF, 1'b1, 32'h0, 24'h0);
    drive_cycle(32'hFFFF_F060, 32'h00A5_A5A5, 1'b1, 32'h0, 24'h0);
    check("led_after_wr", {8'h0, led_out}, 32'h00A5_A5A5);
    peek(32'hFFFF_F060, 32'h0);
    check("led_readback", bus.rdata, 32'h00A5_A5A5);

    // Load mux and switch synchronizer
    peek(32'h0000_0200, 32'h1234_5678);
    check("dram_load", bus.rdata, 32'h1234_5678);
    drive_cycle(32'hFFFF_F070, 32'h0, 1'b0, 32'h0, 24'hF0F0F0);
    drive_cycle(32'hFFFF_F070, 32'h0, 1'b0, 32'h0, 24'hF0F0F0);
    peek(32'hFFFF_F070, 32'h0);
    check("sw_read", bus.rdata, 32'h00F0_F0F0);
    drive_cycle(32'hFFFF_F070, 32'h0, 1'b0, 32'h0, 24'h0F0F0F);
    peek(32'hFFFF_F070, 32'h0);
    check("sw_old_1edge", bus.rdata, 32'h00F0_F0F0);
    drive_cycle(32'hFFFF_F070, 32'h0, 1'b0, 32'h0, 24'h0F0F0F);
    peek(32'hFFFF_F070, 32'h0);
    check("sw_new_2edge", bus.rdata, 32'h000F_0F0F);
    drive_cycle(32'hFFFF_F070, 32'h1234_5678, 1'b1, 32'h0, 24'h0F0F0F);
    peek(32'hFFFF_F070, 32'h0);
    check("sw_write_ignored", bus.rdata, 32'h000F_0F0F);

    // Timer load and wrap
    drive_cycle(32'hFFFF_F020, 32'hFFFF_FFFE, 1'b1, 32'h0, 24'h0F0F0F);
    drive_cycle(32'hFFFF_F020, 32'h0, 1'b0, 32'h0, 24'h0F0F0F);
    peek(32'hFFFF_F020, 32'h0);
    check("timer_ffffffff", bus.rdata, 32'hFFFF_FFFF);
    drive_cycle(32'hFFFF_F020, 32'h0, 1'b0, 32'h0, 24'h0F0F0F);
    peek(32'hFFFF_F020, 32'h0);
    check("timer_wrap", bus.rdata, 32'h0);
    peek(32'hFFFF_F040, 32'h5555_5555);
    check("unmapped_zero", bus.rdata, 32'h0);

    // Scan sequence from a fresh reset
    apply_reset();
    drive_cycle(32'hFFFF_F000, 32'h8765_4321, 1'b1, 32'h0, 24'h0);
    check("scan_cx_dig0", {24'h0, seg_cx}, 32'hF9);
    check("scan_an_dig0", {24'h0, seg_an}, 32'hFE);
    for (int i = 1; i <= 31; i++) begin
      drive_cycle(32'h0000_0010, 32'h0, 1'b0, 32'h0, 24'h0);
      if (i == 3) begin
        check("scan_an_dig1", {24'h0, seg_an}, 32'hFD);
        check("scan_cx_dig1", {24'h0, seg_cx}, 32'hA4);
      end
      if (i == 27) check("scan_an_dig7", {24'h0, seg_an}, 32'h7F);
    end
    check("scan_an_wrap", {24'h0, seg_an}, 32'hFE);
    check("scan_cx_wrap", {24'h0, seg_cx}, 32'hF9);

    // Randomized traffic, mid-run reset, more traffic
    for (int i = 0; i < 500; i++) rand_cycle();
    apply_reset();
    for (int i = 0; i < 200; i++) rand_cycle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
